// File: rtl/dmem_responder.sv
// Multi-cycle 1Kx32 data-memory responder for the MEM stage: valid/ready request, LATENCY wait cycles, one-cycle response, stall.
// Optional feature macro: DMEM_RANGE_CHECK_EN (address range check and resp_err; undefined = address wraps, resp_err tied 0).
module dmem_responder #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
  // req_ready is 1 only in IDLE, resp_valid is a single-cycle pulse in RESP.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  in_range;
  logic                  enter_resp;
  logic                  mem_we;

  // With LATENCY=0 the access completes straight from IDLE, so it must use the live request.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx = acc_addr[ADDR_WIDTH-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (acc_addr < 32'(DEPTH));
`else
  logic unused_hi;
  assign in_range  = 1'b1;
  assign unused_hi = ^acc_addr[31:ADDR_WIDTH];
`endif

  assign enter_resp = ((state_q == S_IDLE) && req_valid && (LATENCY == 0)) ||
                      ((state_q == S_BUSY) && (cnt_q <= 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      valid_d = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
      err_d = !in_range;
`endif
      if (!acc_write) begin
        rdata_d = in_range ? mem[acc_idx] : 32'd0;
      end
    end
    ready_d = (state_d == S_IDLE);
  end

  assign mem_we = enter_resp && acc_write && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; a store aborted by reset never reaches its write edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign stall      = rst_n && (((state_q == S_IDLE) && req_valid) || (state_q == S_BUSY));
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reset checks, directed vector table, LATENCY=0 and reset-abort sequences, random traffic vs reference model.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  logic        v0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic        ready0, rv0, err0, stall0;
  logic [31:0] rdata0;
  logic [1:0]  dbg0;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .dbg_state(dbg_state));

  dmem_responder #(.DEPTH(DEPTH), .ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .req_ready(ready0),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0),
    .stall(stall0), .dbg_state(dbg0));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain array of words plus the last load result.
  logic [31:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] last_rd = 32'd0;
  bit          last_known = 1'b1;
  logic [31:0] exp_q [$];

  task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit rd_known, output bit err);
    bit in_r;
    int idx;
    in_r = RC ? (addr < 32'(DEPTH)) : 1'b1;
    idx  = int'(addr % 32'(DEPTH));
    err  = !in_r;
    if (wr) begin
      if (in_r) begin
        ref_mem[idx] = wdata;
        known[idx]   = 1'b1;
      end
    end else begin
      last_rd    = in_r ? ref_mem[idx] : 32'd0;
      last_known = !in_r || known[idx];
    end
    rd       = last_rd;
    rd_known = last_known;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit err, output int lat,
                       output int stalls, output bit got);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    #1;
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    chk("no_resp_at_accept", {31'd0, resp_valid}, 32'd0);
    stalls = stall ? 1 : 0;
    got = 1'b0; lat = 0; rd = '0; err = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; lat = c; rd = resp_rdata; err = resp_err;
        chk("resp_ready_low", {31'd0, req_ready}, 32'd0);
        chk("resp_stall_low", {31'd0, stall}, 32'd0);
      end else begin
        stalls += stall ? 1 : 0;
      end
      // Churn the request lines while the access is in flight.
      req_valid = got ? 1'b0 : 1'($urandom_range(0, 1));
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    req_valid = 1'b0;
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit use_tab, input logic [31:0] tab_rd, input bit tab_err);
    logic [31:0] m_rd, rd;
    bit m_known, m_err, err, got;
    int lat, stalls;
    model(wr, addr, wdata, m_rd, m_known, m_err);
    if (use_tab) begin m_rd = tab_rd; m_err = tab_err; m_known = 1'b1; end
    drive(wr, addr, wdata, rd, err, lat, stalls, got);
    if (got) begin
      chk("resp_latency", 32'(lat), 32'(LAT + 1));
      chk("stall_cycles", 32'(stalls), 32'(LAT + 1));
      chk("resp_err", {31'd0, err}, {31'd0, m_err});
      if (m_known) begin
        exp_q.push_back(m_rd);
        chk("resp_rdata", rd, exp_q.pop_front());
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tab [9];

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    tab[0] = '{1'b1, 32'd5,          32'hDEADBEEF, 32'd0,                        1'b0};
    tab[1] = '{1'b0, 32'd5,          32'd0,        32'hDEADBEEF,                 1'b0};
    tab[2] = '{1'b1, 32'd0,          32'd0,        32'hDEADBEEF,                 1'b0};
    tab[3] = '{1'b1, 32'd1024,       32'h1234,     32'hDEADBEEF,                 RC};
    tab[4] = '{1'b0, 32'd0,          32'd0,        RC ? 32'd0 : 32'h1234,        1'b0};
    tab[5] = '{1'b1, 32'd1023,       32'hCAFE0001, RC ? 32'd0 : 32'h1234,        1'b0};
    tab[6] = '{1'b0, 32'd1023,       32'd0,        32'hCAFE0001,                 1'b0};
    tab[7] = '{1'b0, 32'hFFFFFFFF,   32'd0,        RC ? 32'd0 : 32'hCAFE0001,    RC};
    tab[8] = '{1'b1, 32'd7,          32'h1,        RC ? 32'd0 : 32'hCAFE0001,    1'b0};

    // Reset state, with a request held high to show stall is forced low.
    req_valid = 1'b1; req_addr = 32'd3; v0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_stall0", {31'd0, stall0}, 32'd0);
    req_valid = 1'b0; v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_req(tab[i].wr, tab[i].addr, tab[i].wdata, 1'b1, tab[i].exp_rd, tab[i].exp_err);

    // Reset during BUSY of a store to addr 7 (currently 0x1).
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'hAAAA;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    last_rd = 32'd0; last_known = 1'b1;
    run_req(1'b0, 32'd7, 32'd0, 1'b1, 32'h1, 1'b0);

    // LATENCY=0 instance.
    @(negedge clk);
    v0 = 1'b1; w0 = 1'b1; a0 = 32'd5; d0 = 32'h1357;
    #1;
    chk("l0_accept_ready", {31'd0, ready0}, 32'd1);
    chk("l0_accept_stall", {31'd0, stall0}, 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    chk("l0_store_resp", {31'd0, rv0}, 32'd1);
    chk("l0_resp_ready", {31'd0, ready0}, 32'd0);
    chk("l0_resp_stall", {31'd0, stall0}, 32'd0);
    @(negedge clk);
    chk("l0_pulse_end", {31'd0, rv0}, 32'd0);
    chk("l0_idle_ready", {31'd0, ready0}, 32'd1);
    v0 = 1'b1; w0 = 1'b0; a0 = 32'd5;
    #1;
    chk("l0_load_stall", {31'd0, stall0}, 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    chk("l0_load_resp", {31'd0, rv0}, 32'd1);
    chk("l0_load_rdata", rdata0, 32'h1357);
    chk("l0_load_err", {31'd0, err0}, 32'd0);
    @(negedge clk);
    chk("l0_load_end", {31'd0, rv0}, 32'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] addr;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'd1024 + 32'($urandom_range(0, 20));
      else             addr = 32'($urandom_range(0, 31));
      run_req(1'($urandom_range(0, 1)), addr, $urandom, 1'b0, 32'd0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
